generate_drbg: RTL and testbench
================================

# generate_drbg

CTR_DRBG generate function (SP 800-90A, AES-256, no derivation function, seedlen 384) for the non-derivative DRBG. It consumes the working state `{key, v, reseed_counter}` produced by instantiate/reseed and streams up to `MAX_BLOCKS` 128-bit pseudorandom blocks. It then performs the backtracking-resistance update and returns the new working state. Block encryption runs on an external shared AES-256 core through a start/done handshake.

## Interface
- `RESEED_INTERVAL`, default 32'h0001_0000: maximum permitted `reseed_counter_in`. It must be less than 2^32-1.
- `MAX_BLOCKS`, default 16: maximum blocks per request, range 1..255.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: request pulse; sampled only in IDLE.
- `num_blocks` in 8: number of output blocks requested.
- `key_in` in 256: working key.
- `v_in` in 128: working V.
- `reseed_counter_in` in 32: working reseed counter.
- `add_valid` in 1: additional input is present.
- `additional_input` in 384: additional input; treated as zero when `add_valid`=0.
- `aes_start` out 1: one-cycle encryption request.
- `aes_key` out 256: cipher key; held stable from `aes_start` until `aes_done`.
- `aes_block` out 128: plaintext; held stable from `aes_start` until `aes_done`.
- `aes_done` in 1: one-cycle pulse that qualifies `aes_result`.
- `aes_result` in 128: ciphertext.
- `out_valid` out 1: `out_data` is valid.
- `out_data` out 128: pseudorandom block.
- `out_ready` in 1: consumer accepts the block.
- `key_out` out 256, `v_out` out 128, `reseed_counter_out` out 32: updated working state.
- `busy` out 1: high whenever the state machine is not in IDLE.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: request rejected; held until the next accepted `start`.

## Operation
- Latched at `start`: all request inputs are captured into internal registers. Inputs may change afterward without effect.
- CHECK: the request is rejected if `reseed_counter_in` > `RESEED_INTERVAL`, `num_blocks`=0, or `num_blocks` > `MAX_BLOCKS`.
  - On rejection: go to COMPLETE with `error`=1.
  - No `aes_start` is issued and no `out_valid` is asserted.
  - `key_out`, `v_out` and `reseed_counter_out` keep their previous values.
- Update(P):
  - Three cipher calls, i = 0..2: V = V+1 mod 2^128, then T_i = AES(K, V).
  - temp = {T_0, T_1, T_2} ^ P, with T_0 in bits [383:256].
  - K = temp[383:128]; V = temp[127:0].
- Pre-update: if `add_valid`=1, run Update(additional_input) before generating.
- Generate loop, per block:
  - V = V+1 mod 2^128.
  - `out_data` = AES(K, V).
  - Hold `out_valid` until `out_ready`.
- Post-update: always run Update(additional_input or 0), using the K and V left after the loop.
- Finish: `key_out`=K, `v_out`=V, `reseed_counter_out` = `reseed_counter_in`+1. Then `done` pulses with `error`=0.
- States and transitions:
  - IDLE → CHECK on `start`.
  - CHECK → COMPLETE on rejection; otherwise to PRE_REQ if `add_valid`, else GEN_REQ.
  - PRE_REQ/PRE_WAIT (×3) → PRE_FIN → GEN_REQ.
  - GEN_REQ → GEN_WAIT → GEN_OUT; GEN_OUT → GEN_REQ for the next block, or POST_REQ after the last.
  - POST_REQ/POST_WAIT (×3) → POST_FIN → COMPLETE → IDLE.
- Two-bit call index for the update calls; 8-bit block counter for the generate loop.
- Wrap: V = all ones increments to zero; there is no carry-out.

## Timing
- Reset values: every output is 0, and the state is IDLE.
- Reset mid-operation: immediate return to IDLE. `aes_start`, `out_valid` and `done` go low, and no partial state is published on `key_out`/`v_out`/`reseed_counter_out`.
- `start` while `busy` is ignored.
- REQ states: `aes_start`=1 for exactly one cycle, with the incremented V on `aes_block` in that same cycle.
- WAIT states: no further `aes_start` is issued. Any `aes_done` seen outside a WAIT state is ignored.
- GEN_OUT: `out_valid` and `out_data` are registered and held stable until the cycle in which `out_ready`=1. There is no buffering, and the next `aes_start` follows acceptance by at least one cycle.
- Latency. Let L = cycles from `aes_start` to `aes_done` (L ≥ 1), with `out_ready` tied high. Counting from the `start` cycle, `done` rises after:
  - 2 + n(L+2) + 3(L+1) + 1 cycles;
  - plus 3(L+1) + 1 more cycles when `add_valid`=1.
- `done` and the new `key_out`/`v_out`/`reseed_counter_out` become visible in the same cycle.

## Test plan
- No additional input: `key_in`=0, `v_in`=0, `reseed_counter_in`=1, `num_blocks`=1, `add_valid`=0, with a bench AES model.
  - `aes_block` sequence is 1, 2, 3, 4.
  - `out_data` = AES(0,1).
  - `key_out` = {AES(0,2), AES(0,3)}; `v_out` = AES(0,4); `reseed_counter_out` = 2.
- Rejection: `reseed_counter_in` = `RESEED_INTERVAL`+1, and separately `num_blocks`=0.
  - `done` and `error` go to 1, with zero `aes_start`, zero `out_valid`, and state outputs unchanged.
- V wrap: `v_in` = 128'hFF…FF, `num_blocks`=2 → first `aes_block` = 0, second = 1.
- Backpressure: `out_ready` held low for 5 cycles during block 1 of 3.
  - `out_valid` and `out_data` stay stable and no `aes_start` is issued during the stall.
  - Exactly 3 blocks are delivered, in order.
- Additional input: `add_valid`=1, `additional_input` = 384'h1, `num_blocks`=1.
  - 7 `aes_start` pulses in total.
  - Post-update XOR is applied to bit 0 of `v_out`, checked against the model.
- Reset: `rst_n` low during GEN_WAIT of block 2.
  - All outputs go to 0 asynchronously.
  - A new `start` afterward completes normally.

Source files
------------

// File: rtl/generate_drbg.sv
// rtl/generate_drbg.sv - CTR_DRBG (AES-256, no df) generate function with backtracking-resistance update
module generate_drbg #(
    parameter logic [31:0] RESEED_INTERVAL = 32'h0001_0000,
    parameter int          MAX_BLOCKS      = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [7:0]   num_blocks,
    input  logic [255:0] key_in,
    input  logic [127:0] v_in,
    input  logic [31:0]  reseed_counter_in,
    input  logic         add_valid,
    input  logic [383:0] additional_input,
    output logic         aes_start,
    output logic [255:0] aes_key,
    output logic [127:0] aes_block,
    input  logic         aes_done,
    input  logic [127:0] aes_result,
    output logic         out_valid,
    output logic [127:0] out_data,
    input  logic         out_ready,
    output logic [255:0] key_out,
    output logic [127:0] v_out,
    output logic [31:0]  reseed_counter_out,
    output logic         busy,
    output logic         done,
    output logic         error
);

    localparam logic [7:0] MAX_B = 8'(MAX_BLOCKS);

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_PRE_REQ, S_PRE_WAIT, S_PRE_FIN,
        S_GEN_REQ, S_GEN_WAIT, S_GEN_OUT,
        S_POST_REQ, S_POST_WAIT, S_POST_FIN, S_COMPLETE
    } state_t;

    state_t         state;
    logic [255:0]   key_r;
    logic [127:0]   v_r;
    logic [31:0]    rc_r;
    logic [7:0]     num_r;
    logic [7:0]     blk_cnt;
    logic [1:0]     call_idx;
    logic           add_valid_r;
    logic [383:0]   add_r;
    logic [255:0]   t_r;

    // Cipher request fields come straight from the working registers, which only
    // change on the cycle a new request is launched or after the last update call.
    assign aes_key   = key_r;
    assign aes_block = v_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            key_r              <= '0;
            v_r                <= '0;
            rc_r               <= '0;
            num_r              <= '0;
            blk_cnt            <= '0;
            call_idx           <= '0;
            add_valid_r        <= 1'b0;
            add_r              <= '0;
            t_r                <= '0;
            aes_start          <= 1'b0;
            out_valid          <= 1'b0;
            out_data           <= '0;
            key_out            <= '0;
            v_out              <= '0;
            reseed_counter_out <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            error              <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        key_r       <= key_in;
                        v_r         <= v_in;
                        rc_r        <= reseed_counter_in;
                        num_r       <= num_blocks;
                        add_valid_r <= add_valid;
                        add_r       <= add_valid ? additional_input : '0;
                        error       <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    blk_cnt  <= '0;
                    call_idx <= '0;
                    if (rc_r > RESEED_INTERVAL || num_r == 8'd0 || num_r > MAX_B) begin
                        done  <= 1'b1;
                        error <= 1'b1;
                        state <= S_COMPLETE;
                    end else begin
                        v_r       <= v_r + 128'd1;
                        aes_start <= 1'b1;
                        state     <= add_valid_r ? S_PRE_REQ : S_GEN_REQ;
                    end
                end
                S_PRE_REQ: begin
                    aes_start <= 1'b0;
                    state     <= S_PRE_WAIT;
                end
                S_POST_REQ: begin
                    aes_start <= 1'b0;
                    state     <= S_POST_WAIT;
                end
                S_PRE_WAIT, S_POST_WAIT: begin
                    if (aes_done) begin
                        if (call_idx == 2'd2) begin
                            // temp = {T0,T1,T2} ^ P split into new K and V
                            key_r <= t_r ^ add_r[383:128];
                            v_r   <= aes_result ^ add_r[127:0];
                            state <= (state == S_PRE_WAIT) ? S_PRE_FIN : S_POST_FIN;
                        end else begin
                            if (call_idx == 2'd0)
                                t_r[255:128] <= aes_result;
                            else
                                t_r[127:0]   <= aes_result;
                            call_idx  <= call_idx + 2'd1;
                            v_r       <= v_r + 128'd1;
                            aes_start <= 1'b1;
                            state     <= (state == S_PRE_WAIT) ? S_PRE_REQ : S_POST_REQ;
                        end
                    end
                end
                S_PRE_FIN: begin
                    v_r       <= v_r + 128'd1;
                    aes_start <= 1'b1;
                    state     <= S_GEN_REQ;
                end
                S_GEN_REQ: begin
                    aes_start <= 1'b0;
                    state     <= S_GEN_WAIT;
                end
                S_GEN_WAIT: begin
                    if (aes_done) begin
                        out_data  <= aes_result;
                        out_valid <= 1'b1;
                        blk_cnt   <= blk_cnt + 8'd1;
                        state     <= S_GEN_OUT;
                    end
                end
                S_GEN_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        v_r       <= v_r + 128'd1;
                        aes_start <= 1'b1;
                        call_idx  <= '0;
                        state     <= (blk_cnt == num_r) ? S_POST_REQ : S_GEN_REQ;
                    end
                end
                S_POST_FIN: begin
                    key_out            <= key_r;
                    v_out              <= v_r;
                    reseed_counter_out <= rc_r + 32'd1;
                    done               <= 1'b1;
                    state              <= S_COMPLETE;
                end
                S_COMPLETE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_generate_drbg.sv
// tb/tb_generate_drbg.sv - directed table-driven bench for generate_drbg with a stand-in cipher model
module tb_generate_drbg;

    localparam logic [31:0] RI = 32'h0001_0000;
    localparam int          MB = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   num_blocks = '0;
    logic [255:0] key_in = '0;
    logic [127:0] v_in = '0;
    logic [31:0]  reseed_counter_in = '0;
    logic         add_valid = 1'b0;
    logic [383:0] additional_input = '0;
    logic         aes_start;
    logic [255:0] aes_key;
    logic [127:0] aes_block;
    logic         aes_done = 1'b0;
    logic [127:0] aes_result = '0;
    logic         out_valid;
    logic [127:0] out_data;
    logic         out_ready = 1'b1;
    logic [255:0] key_out;
    logic [127:0] v_out;
    logic [31:0]  reseed_counter_out;
    logic         busy;
    logic         done;
    logic         error;

    generate_drbg #(.RESEED_INTERVAL(RI), .MAX_BLOCKS(MB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_blocks(num_blocks),
        .key_in(key_in), .v_in(v_in), .reseed_counter_in(reseed_counter_in),
        .add_valid(add_valid), .additional_input(additional_input),
        .aes_start(aes_start), .aes_key(aes_key), .aes_block(aes_block),
        .aes_done(aes_done), .aes_result(aes_result),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .key_out(key_out), .v_out(v_out), .reseed_counter_out(reseed_counter_out),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int lat = 2;
    int n_starts = 0;
    logic [127:0] blk_q[$];
    logic [127:0] out_q[$];
    logic [127:0] exp_blk_q[$];
    logic [127:0] exp_out_q[$];
    logic [255:0] exp_key, prev_key;
    logic [127:0] exp_v, prev_v;
    logic [31:0]  prev_rc;

    // Stand-in for AES-256: cheap, key- and block-dependent, bijective in the block.
    function automatic logic [127:0] aes_m(input logic [255:0] k, input logic [127:0] b);
        return {b[114:0], b[127:115]} ^ k[255:128] ^ {k[126:0], k[127]}
               ^ 128'hC3A5_5A3C_0F1E_2D3C_4B5A_6978_8796_A5B4;
    endfunction

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic ref_update(inout logic [255:0] k, inout logic [127:0] v, input logic [383:0] p);
        logic [383:0] t;
        for (int i = 0; i < 3; i++) begin
            v = v + 128'd1;
            exp_blk_q.push_back(v);
            t[383 - 128*i -: 128] = aes_m(k, v);
        end
        t = t ^ p;
        k = t[383:128];
        v = t[127:0];
    endtask

    task automatic ref_gen(input logic [255:0] k0, input logic [127:0] v0, input int n,
                           input logic av, input logic [383:0] ad);
        logic [255:0] k;
        logic [127:0] v;
        logic [383:0] p;
        k = k0; v = v0;
        p = av ? ad : '0;
        exp_blk_q.delete();
        exp_out_q.delete();
        if (av) ref_update(k, v, p);
        for (int i = 0; i < n; i++) begin
            v = v + 128'd1;
            exp_blk_q.push_back(v);
            exp_out_q.push_back(aes_m(k, v));
        end
        ref_update(k, v, p);
        exp_key = k;
        exp_v   = v;
    endtask

    // Cipher responder: answers each request L cycles after its aes_start cycle.
    initial begin
        logic [255:0] rk;
        logic [127:0] rb;
        forever begin
            @(negedge clk);
            if (rst_n && aes_start) begin
                rk = aes_key;
                rb = aes_block;
                repeat (lat) @(posedge clk);
                #1 aes_done = 1'b1;
                aes_result = aes_m(rk, rb);
                @(posedge clk);
                #1 aes_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (aes_start) begin
                n_starts++;
                blk_q.push_back(aes_block);
            end
            if (out_valid && out_ready) out_q.push_back(out_data);
        end
    end

    typedef struct {
        logic [255:0] key;
        logic [127:0] v;
        logic [31:0]  rc;
        logic [7:0]   n;
        logic         av;
        logic [383:0] ad;
        int           lat;
        logic         exp_err;
        int           exp_starts;
        logic [127:0] exp_first;
    } vec_t;

    vec_t vecs[8];
    int   st_base, blk_base, out_base;

    task automatic apply_inputs(input vec_t t);
        key_in = t.key; v_in = t.v; reseed_counter_in = t.rc; num_blocks = t.n;
        add_valid = t.av; additional_input = t.ad; lat = t.lat;
        st_base = n_starts; blk_base = blk_q.size(); out_base = out_q.size();
    endtask

    task automatic run_vec(input int idx, input vec_t t);
        int cyc;
        int exp_lat;
        string tag;
        tag = $sformatf("v%0d", idx);
        apply_inputs(t);
        start = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end while (!done && cyc < 3000);
        chk({tag, "_done_seen"}, 384'(done), 384'(1));
        exp_lat = t.exp_err ? 2 : 2 + t.n*(t.lat+2) + 3*(t.lat+1) + 1 + (t.av ? 3*(t.lat+1)+1 : 0);
        chk({tag, "_latency"}, 384'(cyc), 384'(exp_lat));
        chk({tag, "_error"}, 384'(error), 384'(t.exp_err));
        chk({tag, "_aes_starts"}, 384'(n_starts - st_base), 384'(t.exp_starts));
        if (t.exp_starts > 0 && blk_q.size() > blk_base)
            chk({tag, "_first_block"}, 384'(blk_q[blk_base]), 384'(t.exp_first));
        if (t.exp_err) begin
            chk({tag, "_out_count"}, 384'(out_q.size() - out_base), 384'(0));
            chk({tag, "_key_kept"}, 384'(key_out), 384'(prev_key));
            chk({tag, "_v_kept"}, 384'(v_out), 384'(prev_v));
            chk({tag, "_rc_kept"}, 384'(reseed_counter_out), 384'(prev_rc));
        end else begin
            ref_gen(t.key, t.v, int'(t.n), t.av, t.ad);
            for (int i = 0; i < exp_blk_q.size() && blk_base + i < blk_q.size(); i++)
                chk($sformatf("%s_aes_block%0d", tag, i), 384'(blk_q[blk_base+i]), 384'(exp_blk_q[i]));
            chk({tag, "_out_count"}, 384'(out_q.size() - out_base), 384'(t.n));
            for (int i = 0; i < exp_out_q.size() && out_base + i < out_q.size(); i++)
                chk($sformatf("%s_out%0d", tag, i), 384'(out_q[out_base+i]), 384'(exp_out_q[i]));
            chk({tag, "_key_out"}, 384'(key_out), 384'(exp_key));
            chk({tag, "_v_out"}, 384'(v_out), 384'(exp_v));
            chk({tag, "_rc_out"}, 384'(reseed_counter_out), 384'(t.rc + 32'd1));
            prev_key = exp_key; prev_v = exp_v; prev_rc = t.rc + 32'd1;
        end
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, 384'(done), 384'(0));
        chk({tag, "_idle"}, 384'(busy), 384'(0));
    endtask

    initial begin
        logic [127:0] held;
        int s0, cyc;
        logic stable;

        vecs[0] = '{key: '0, v: '0, rc: 32'd1, n: 8'd1, av: 1'b0, ad: 384'hDEAD, lat: 2,
                    exp_err: 1'b0, exp_starts: 4, exp_first: 128'd1};
        vecs[1] = '{key: 256'h1234, v: 128'd5, rc: RI + 32'd1, n: 8'd1, av: 1'b0, ad: '0, lat: 2,
                    exp_err: 1'b1, exp_starts: 0, exp_first: '0};
        vecs[2] = '{key: 256'h1234, v: 128'd5, rc: 32'd3, n: 8'd0, av: 1'b0, ad: '0, lat: 2,
                    exp_err: 1'b1, exp_starts: 0, exp_first: '0};
        vecs[3] = '{key: 256'h0123_4567_89AB_CDEF, v: '1, rc: 32'd5, n: 8'd2, av: 1'b0, ad: '0, lat: 1,
                    exp_err: 1'b0, exp_starts: 5, exp_first: 128'd0};
        vecs[4] = '{key: 256'hFEED, v: 128'h10, rc: 32'd7, n: 8'd1, av: 1'b1, ad: 384'h1, lat: 2,
                    exp_err: 1'b0, exp_starts: 7, exp_first: 128'h11};
        vecs[5] = '{key: 256'h77, v: 128'h100, rc: RI, n: 8'(MB), av: 1'b0, ad: '0, lat: 1,
                    exp_err: 1'b0, exp_starts: MB + 3, exp_first: 128'h101};
        vecs[6] = '{key: 256'h77, v: 128'h100, rc: 32'd2, n: 8'(MB + 1), av: 1'b0, ad: '0, lat: 1,
                    exp_err: 1'b1, exp_starts: 0, exp_first: '0};
        vecs[7] = '{key: 256'h5555, v: 128'h2000, rc: 32'd0, n: 8'd3, av: 1'b1,
                    ad: 384'hABCDEF << 200, lat: 3,
                    exp_err: 1'b0, exp_starts: 9, exp_first: 128'h2001};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", 384'({aes_start, out_valid, done, busy, error}), 384'(0));
        chk("reset_state", 384'({key_out, v_out, reseed_counter_out}), 384'(0));
        chk("reset_aes", 384'({aes_key, aes_block}), 384'(0));
        rst_n = 1'b1;
        prev_key = '0; prev_v = '0; prev_rc = '0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
            if (i == 0) begin
                chk("nai_key_hand", 384'(key_out), 384'({aes_m('0, 128'd2), aes_m('0, 128'd3)}));
                chk("nai_v_hand", 384'(v_out), 384'(aes_m('0, 128'd4)));
                chk("nai_out_hand", 384'(out_q[out_q.size()-1]), 384'(aes_m('0, 128'd1)));
            end
            if (i == 3) chk("wrap_second_block", 384'(blk_q[blk_base+1]), 384'(1));
        end

        // Backpressure on the middle block of three, with a start pulse while busy.
        apply_inputs('{key: 256'hBEEF, v: 128'h40, rc: 32'd9, n: 8'd3, av: 1'b0, ad: '0, lat: 2,
                       exp_err: 1'b0, exp_starts: 6, exp_first: 128'h41});
        start = 1'b1;
        cyc = 0;
        do begin @(posedge clk); #1; start = 1'b0; cyc++; end
        while (out_q.size() - out_base < 1 && cyc < 200);
        out_ready = 1'b0;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!out_valid && cyc < 50);
        chk("bp_block1_valid", 384'(out_valid), 384'(1));
        held = out_data;
        s0 = n_starts;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_data !== held) stable = 1'b0;
        end
        start = 1'b0;
        chk("bp_stable", 384'(stable), 384'(1));
        chk("bp_no_aes_start", 384'(n_starts), 384'(s0));
        out_ready = 1'b1;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!done && cyc < 500);
        chk("bp_done_seen", 384'(done), 384'(1));
        ref_gen(256'hBEEF, 128'h40, 3, 1'b0, '0);
        chk("bp_out_count", 384'(out_q.size() - out_base), 384'(3));
        for (int i = 0; i < 3 && out_base + i < out_q.size(); i++)
            chk($sformatf("bp_out%0d", i), 384'(out_q[out_base+i]), 384'(exp_out_q[i]));
        chk("bp_aes_starts", 384'(n_starts - st_base), 384'(6));
        chk("bp_key_out", 384'(key_out), 384'(exp_key));
        chk("bp_rc_out", 384'(reseed_counter_out), 384'(32'd10));
        @(posedge clk); #1;

        // Asynchronous reset during GEN_WAIT of block 2.
        apply_inputs(vecs[0]);
        num_blocks = 8'd3;
        start = 1'b1;
        cyc = 0;
        do begin @(posedge clk); #1; start = 1'b0; cyc++; end
        while (n_starts - st_base < 2 && cyc < 200);
        chk("rst_reached_gen_wait", 384'(n_starts - st_base), 384'(2));
        rst_n = 1'b0;
        #1;
        chk("rst_ctrl_low", 384'({aes_start, out_valid, done, busy, error}), 384'(0));
        chk("rst_state_cleared", 384'({key_out, v_out, reseed_counter_out}), 384'(0));
        chk("rst_data_cleared", 384'({out_data, aes_block}), 384'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        prev_key = '0; prev_v = '0; prev_rc = '0;
        repeat (5) @(posedge clk);
        #1;
        run_vec(8, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
